miyajiro_uart_rx: RTL and testbench
===================================

// Module: miyajiro_uart_rx
// PURPOSE
//   UART receiver (8N1, LSB first) feeding bytes to the CPU side of miyajiro_cpu_wrapper.
//   - Oversamples the serial line in the divided CPU clock domain.
//   - Delivers each byte through a valid/ready handshake.
//   - Flags framing and overrun errors.
//   - Counterpart to the wrapper's UART transmit path; sits between the board RX pin and CPU I/O.
// PARAMETERS
//   CLKS_PER_BIT  43  clk cycles per UART bit (5 MHz / 115200); legal range >= 4
//   CNT_W         $clog2(CLKS_PER_BIT)  bit-timer width (derived, not overridden)
// PORTS
//   clk         in   1  single clock; all logic on posedge
//   reset       in   1  asynchronous, active-high reset
//   rxd         in   1  serial line, idle high, asynchronous to clk
//   rx_data     out  8  received byte, stable while rx_valid=1
//   rx_valid    out  1  byte available; held until accepted
//   rx_ready    in   1  consumer accepts byte when rx_valid & rx_ready at posedge
//   frame_err   out  1  1-cycle pulse: stop bit sampled low
//   overrun     out  1  1-cycle pulse: byte completed while rx_valid still 1
// BEHAVIOUR
//   - Reset values (async): state=IDLE, sync flops=1, rx_data=0, rx_valid=0, frame_err=0,
//     overrun=0, bit timer=0, bit index=0. Reset mid-frame abandons the frame; no partial byte is kept.
//   - rxd passes through a 2-flop synchronizer (reset to 1). "rxs" denotes the synchronized value.
//   - FSM states: IDLE, START, DATA, STOP (plus PARITY under the macro below).
//     - IDLE: rxs==0 at posedge t0 -> START; timer loaded with CLKS_PER_BIT/2-1.
//     - START: at timer==0 (mid start bit), rxs==0 -> DATA with timer=CLKS_PER_BIT-1 and
//       bit index=0; rxs==1 -> IDLE (glitch rejected, no flags).
//     - DATA: at each timer expiry, sample rxs into shift[bit index] (LSB first) and reload
//       the timer. After bit 7 -> STOP.
//     - STOP: at timer expiry, sample rxs and return to IDLE on the same edge. Resync on the
//       next start bit is allowed half a bit early.
//       - rxs==1 and rx_valid==0: rx_data<=shift, rx_valid<=1 on the next cycle.
//       - rxs==1 and rx_valid==1: new byte dropped, old rx_data kept, overrun pulses 1 cycle.
//       - rxs==0: frame_err pulses 1 cycle, byte dropped, rx_valid unchanged.
//   - Latency: stop sample at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles; rx_valid rises 1 cycle later.
//   - Handshake: rx_valid & rx_ready clears rx_valid on that posedge.
//     - If accept and stop-sample success coincide, the accept wins: new byte loads, rx_valid stays 1,
//       no overrun.
//     - rx_ready while rx_valid=0 is ignored.
//   - Timer decrements to 0 then reloads; it never wraps below 0. Bit index is 3 bits; completion
//     is detected at index 7, with no wrap past it.
//   - rxd held low indefinitely (break): one frame_err, then IDLE waits for rxs==1 before
//     re-arming edge detect.
// CONFIGURATION
//   MIYAJIRO_UART_RX_PARITY_EN
//   - Defined: 8E1 framing. A PARITY state between DATA and STOP samples one bit.
//     - Mismatch with even parity over the 8 data bits pulses output parity_err (1 bit, reset 0)
//       and drops the byte.
//     - Stop sample occurs 1 bit later; latency +CLKS_PER_BIT.
//   - Undefined: 8N1 as above. The PARITY state and the parity_err port do not exist.
// TESTING  (bench uses CLKS_PER_BIT=16)
//   - Send 0x55 8N1, rx_ready=1 -> rx_valid 1 cycle at t0+153 with rx_data=0x55; no flags.
//   - Drive rxd low for 4 cycles then high -> START rejects; no rx_valid, no flags; FSM returns to IDLE.
//   - Send 0xA3 with stop bit 0 -> frame_err 1-cycle pulse; rx_valid stays 0.
//   - Send 0x01 then 0x02 back-to-back, rx_ready=0 -> rx_data=0x01 held, overrun pulse at 0x02's stop;
//     after rx_ready=1 for 1 cycle, rx_valid=0.
//   - Assert reset mid-DATA of 0xFF -> all outputs 0 immediately; release; send 0x3C -> rx_data=0x3C.
//   - With MIYAJIRO_UART_RX_PARITY_EN: 0x07 with parity bit 1 -> accepted; with parity bit 0 ->
//     parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/miyajiro_uart_rx.sv
// miyajiro_uart_rx: UART receiver (8N1, LSB first) with a valid/ready byte output.
// Oversamples the 2-flop-synchronized serial line. It reports framing errors and
// overruns as single-cycle pulses.
// Define MIYAJIRO_UART_RX_PARITY_EN for 8E1 framing. That build adds a PARITY
// state and a parity_err pulse output.
module miyajiro_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 43,
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
`ifdef MIYAJIRO_UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

`ifdef MIYAJIRO_UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic             rx_meta;
    logic             rxs;
    logic [CNT_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             armed;
    logic             timer_done;
`ifdef MIYAJIRO_UART_RX_PARITY_EN
    logic             parity_bad;
`endif

    assign timer_done = (timer == '0);

    // Two-flop synchronizer for the asynchronous serial line (idle high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // Receive FSM: start detection, bit sampling, stop check and output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            armed      <= 1'b1;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef MIYAJIRO_UART_RX_PARITY_EN
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef MIYAJIRO_UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // After a break, the line must return high before a new start edge counts.
                    if (!rxs && armed) begin
                        state <= START;
                        timer <= HALF_LOAD;
                    end else if (rxs) begin
                        armed <= 1'b1;
                    end
                end

                START: begin
                    if (!timer_done) begin
                        timer <= timer - CNT_W'(1);
                    end else if (!rxs) begin
                        state   <= DATA;
                        timer   <= FULL_LOAD;
                        bit_idx <= 3'd0;
                    end else begin
                        state <= IDLE;
                    end
                end

                DATA: begin
                    if (!timer_done) begin
                        timer <= timer - CNT_W'(1);
                    end else begin
                        shift[bit_idx] <= rxs;
                        timer          <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef MIYAJIRO_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

`ifdef MIYAJIRO_UART_RX_PARITY_EN
                PARITY: begin
                    if (!timer_done) begin
                        timer <= timer - CNT_W'(1);
                    end else begin
                        parity_bad <= (^shift) ^ rxs;
                        parity_err <= (^shift) ^ rxs;
                        timer      <= FULL_LOAD;
                        state      <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (!timer_done) begin
                        timer <= timer - CNT_W'(1);
                    end else begin
                        state   <= IDLE;
                        bit_idx <= 3'd0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
`ifdef MIYAJIRO_UART_RX_PARITY_EN
                        end else if (parity_bad) begin
                            parity_bad <= 1'b0;
`endif
                        end else if (!rx_valid || rx_ready) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
`ifdef MIYAJIRO_UART_RX_PARITY_EN
                        if (!rxs) begin
                            parity_bad <= 1'b0;
                        end
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miyajiro_uart_rx.sv
// tb_miyajiro_uart_rx: scoreboard bench for miyajiro_uart_rx at 16 clocks per bit.
// The driver pushes the expected bytes and flag pulses. A negedge monitor pops
// and compares them. Set MIYAJIRO_UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_miyajiro_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef MIYAJIRO_UART_RX_PARITY_EN
    logic       parity_err;
`endif

    miyajiro_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
`ifdef MIYAJIRO_UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        int unsigned acc_cyc;   // expected accept edge, 0 = any
    } exp_t;

    exp_t data_q[$];
    int   fe_pend = 0;
    int   ov_pend = 0;
    int   pe_pend = 0;
    int   checks = 0;
    int   failures = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted byte and every flag pulse with the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                checks++;
                if (data_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                end else begin
                    e = data_q.pop_front();
                    if (rx_data !== e.data) begin
                        failures++;
                        $display("FAIL rx_data: got %0h expected %0h", rx_data, e.data);
                    end
                    if (e.acc_cyc != 0) begin
                        checks++;
                        if (cyc + 1 != e.acc_cyc) begin
                            failures++;
                            $display("FAIL latency: accept at cycle %0d expected %0d", cyc + 1, e.acc_cyc);
                        end
                    end
                end
            end
            if (frame_err) begin
                checks++;
                if (fe_pend == 0) begin
                    failures++;
                    $display("FAIL frame_err: got pulse expected none");
                end else fe_pend--;
            end
            if (overrun) begin
                checks++;
                if (ov_pend == 0) begin
                    failures++;
                    $display("FAIL overrun: got pulse expected none");
                end else ov_pend--;
            end
`ifdef MIYAJIRO_UART_RX_PARITY_EN
            if (parity_err) begin
                checks++;
                if (pe_pend == 0) begin
                    failures++;
                    $display("FAIL parity_err: got pulse expected none");
                end else pe_pend--;
            end
`endif
        end
    end

    // Random consumer backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rx_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef MIYAJIRO_UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop_bit);
    endtask

    // Reference rule: a bad stop bit flags frame_err, a bad parity bit flags parity_err,
    // and otherwise the byte is delivered (the consumer is assumed to keep up).
    task automatic expect_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                                input int unsigned acc_cyc);
        exp_t e;
        if (!stop_bit) begin
            fe_pend++;
`ifdef MIYAJIRO_UART_RX_PARITY_EN
            if (par_flip) pe_pend++;
`endif
        end
`ifdef MIYAJIRO_UART_RX_PARITY_EN
        else if (par_flip) pe_pend++;
`endif
        else begin
            e.data    = d;
            e.acc_cyc = acc_cyc;
            data_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input bit need_data);
        int n = 0;
        while ((fe_pend != 0 || ov_pend != 0 || pe_pend != 0 ||
                (need_data && data_q.size() != 0)) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL %s: timeout fe=%0d ov=%0d pe=%0d bytes=%0d expected all 0",
                     name, fe_pend, ov_pend, pe_pend, data_q.size());
        end
    endtask

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e0;
        logic [7:0]  d;
        logic        sb;
        logic        pf;
        int          gap;

        reset    = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 0x55: accept edge at t0+153, where t0 is 3 edges after the line falls.
        e0 = cyc;
        expect_frame(8'h55, 1'b1, 1'b0, e0 + 3 + 153);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_drain("drain_55", 1'b1);
        send_bit(1'b1);

        // Short glitch: START rejects it and nothing is reported.
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_rx_valid", 32'(rx_valid), 32'd0);
        expect_frame(8'h5A, 1'b1, 1'b0, 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_drain("drain_5a", 1'b1);

        // Bad stop bit.
        expect_frame(8'hA3, 1'b0, 1'b0, 0);
        send_frame(8'hA3, 1'b0, 1'b0);
        send_bit(1'b1);
        wait_drain("drain_a3", 1'b1);
        chk("frame_err_rx_valid", 32'(rx_valid), 32'd0);

        // Overrun: two back-to-back frames with the consumer stalled.
        rx_ready = 1'b0;
        expect_frame(8'h01, 1'b1, 1'b0, 0);
        ov_pend++;
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        wait_drain("drain_overrun", 1'b0);
        chk("overrun_rx_data", 32'(rx_data), 32'h01);
        chk("overrun_rx_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        chk("after_accept_rx_valid", 32'(rx_valid), 32'd0);
        chk("after_accept_queue", 32'(data_q.size()), 32'd0);
        rx_ready = 1'b1;
        send_bit(1'b1);

        // Reset in the middle of 0xFF, then 0x3C must arrive intact.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset = 1'b1;
        #1;
        chk("midreset_rx_data", 32'(rx_data), 32'd0);
        chk("midreset_rx_valid", 32'(rx_valid), 32'd0);
        chk("midreset_flags", 32'({frame_err, overrun}), 32'd0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        send_bit(1'b1);
        expect_frame(8'h3C, 1'b1, 1'b0, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_drain("drain_3c", 1'b1);

        // Break: one frame_err only, then the receiver re-arms once the line is high.
        fe_pend++;
        rxd = 1'b0;
        repeat (12 * CPB) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        wait_drain("drain_break", 1'b1);
        expect_frame(8'hC3, 1'b1, 1'b0, 0);
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_drain("drain_c3", 1'b1);

`ifdef MIYAJIRO_UART_RX_PARITY_EN
        expect_frame(8'h07, 1'b1, 1'b0, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain("drain_par_ok", 1'b1);
        expect_frame(8'h07, 1'b1, 1'b1, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_drain("drain_par_bad", 1'b1);
        chk("parity_bad_rx_valid", 32'(rx_valid), 32'd0);
`endif

        // Random frames with random gaps and consumer stalls.
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            d   = 8'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
`ifdef MIYAJIRO_UART_RX_PARITY_EN
            pf  = ($urandom_range(0, 4) == 0);
`else
            pf  = 1'b0;
`endif
            gap = int'($urandom_range(0, 20));
            expect_frame(d, sb, pf, 0);
            send_frame(d, sb, pf);
            if (!sb) gap = gap + int'(CPB);
            rxd = 1'b1;
            repeat (gap) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        wait_drain("drain_random", 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("final_rx_valid", 32'(rx_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
